// File: rtl/q_result_reader.sv
// Result FIFO between the Q datapath and a 32-bit consumer: buffers raw Q words,
// saturates on the read side and counts results lost while the buffer is full.
module q_result_reader #(
    parameter int DEPTH  = 8,
    parameter int Q_W    = 36,
    parameter int OUT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Q_W-1:0]          q_in,
    input  logic                    q_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    full,
    output logic                    empty,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [Q_W-1:0]    mem_q [DEPTH];
    logic [Q_W-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic             push, pop, drop;
    logic [Q_W-1:0]   head;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign out_valid  = !empty;
    assign fifo_count = count_q;
    assign drop_count = drop_q;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign pop  = out_valid & out_ready;
    assign push = q_valid & (!full | pop);
    assign drop = q_valid & full & !pop;

    assign head     = mem_q[rd_ptr_q];
    assign out_ovf  = |head[Q_W-1:OUT_W];
    assign out_data = out_ovf ? '1 : head[OUT_W-1:0];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;

        if (push) begin
            mem_d[wr_ptr_q] = q_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/q_result_reader.md
Name: q_result_reader

Overview:
- Receive side for the operand/result datapath: captures 36-bit Q results as they are produced and buffers them in a small FIFO.
- Presents each result downstream as a 32-bit word, saturated when needed, with a valid/ready handshake.
- Flags results that do not fit in 32 bits.
- Counts results dropped because the buffer was full, so the consumer can stall without silent loss going unnoticed.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- Q_W, 36, input result width.
- OUT_W, 32, output data width; must be less than Q_W.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all logic acts on the rising edge.
- rst  input  1  synchronous active-high reset.
- q_in  input  Q_W  result word from the datapath.
- q_valid  input  1  q_in carries a new result this cycle.
- out_data  output  OUT_W  head-of-FIFO result, saturated.
- out_ovf  output  1  head result had nonzero bits above OUT_W-1.
- out_valid  output  1  FIFO is not empty.
- out_ready  input  1  consumer accepts the head this cycle.
- fifo_count  output  log2(DEPTH)+1  current occupancy.
- full  output  1  fifo_count == DEPTH.
- empty  output  1  fifo_count == 0.
- drop_count  output  DROP_W  number of results discarded.

Behaviour:
- Reset: synchronous; takes priority over every other event.
  - Read/write pointers, fifo_count and drop_count go to 0.
  - empty=1, full=0, out_valid=0.
  - out_data and out_ovf are don't-care while out_valid=0; the bench checks them only when out_valid=1.
  - Reset in mid-operation discards all stored entries; q_valid in the reset cycle is ignored.
- Pop:
  - pop = out_valid & out_ready.
  - The head advances at the clock edge.
  - out_ready while empty has no effect.
- Push:
  - push = q_valid & (!full | pop).
  - With the FIFO full, a simultaneous pop frees a slot, so the write is accepted.
- Drop:
  - drop = q_valid & full & !pop.
  - The entry is discarded and drop_count increments.
  - drop_count saturates at all-ones and never wraps.
- Occupancy: fifo_count += push - pop. Simultaneous push and pop leave the count unchanged.
- Pointers wrap modulo DEPTH.
- Storage: each entry stores the full Q_W bits; conversion is done on the read side.
  - out_ovf = |head[Q_W-1:OUT_W].
  - out_data = all-ones when out_ovf=1, else head[OUT_W-1:0].
- Latency:
  - A result pushed at edge N appears on out_valid/out_data after edge N, i.e. it is visible in cycle N+1.
  - There is no combinational bypass from q_in to out_data, even when the FIFO is empty.
- Output stability: out_data/out_ovf remain stable while out_valid=1 and out_ready=0.
- Ordering: results are delivered strictly in arrival order.
- State: there is no explicit FSM. State is held entirely in the pointers, fifo_count and drop_count, and full/empty are derived from fifo_count.

Test Plan:
1. Reset, then push q_in=36'h0_0000_000E for 1 cycle with out_ready=0.
   - Next cycle: out_valid=1, out_data=32'h0000000E, out_ovf=0, fifo_count=1.
   - Hold for 5 cycles: the outputs stay stable.
2. Push 0x7, 0x3, 0x7 on consecutive cycles with out_ready=1 from the second cycle on.
   - Outputs appear in order 7, 3, 7, one per cycle.
   - fifo_count never exceeds 2 and returns to 0; empty=1 at the end.
3. Push q_in=36'h1_0000_0005.
   - out_data=32'hFFFFFFFF, out_ovf=1.
   - Then push 36'h0_FFFF_FFFF: out_data=32'hFFFFFFFF, out_ovf=0.
4. With out_ready=0, push 10 values 1..10.
   - full=1 after the 8th push; drop_count=2.
   - Popping then yields 1..8 only.
5. With the FIFO full, assert q_valid=1 (value 0x99) and out_ready=1 in the same cycle.
   - Head pops, 0x99 is accepted, fifo_count stays 8, drop_count is unchanged.
6. Fill with 5 entries, then assert rst for 1 cycle while q_valid=1.
   - fifo_count=0, out_valid=0, drop_count=0.
   - A next push of 0x4 is the first value out.
